// File: rtl/keyspace_pkg.sv
// keyspace_pkg: shared FSM encoding and widths for the keyspace generator
package keyspace_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, FOUND, DONE} state_t;
    localparam int MD5_W = 128;
    localparam int TRIED_W = 48;
endpackage

// File: rtl/mixed_radix_counter.sv
// mixed_radix_counter: lane/stride digit counter with length-limited carry chain
module mixed_radix_counter #(
    parameter int MAX_LEN = 8,
    parameter int CS_BITS = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              init,
    input  logic                              inc,
    input  logic [CS_BITS-1:0]                lane,
    input  logic [CS_BITS-1:0]                lanes,
    input  logic [CS_BITS:0]                  n,
    input  logic [3:0]                        len,
    output logic [MAX_LEN-1:0][CS_BITS-1:0]   digits,
    output logic                              last
);
    logic [MAX_LEN:0] c;
    logic [MAX_LEN-1:0][CS_BITS-1:0] nxt;
    logic [CS_BITS:0] s, w;
    // last reports that incrementing now would carry out of the top digit
    always_comb begin
        c = '0;
        nxt = digits;
        last = 1'b0;
        s = '0;
        w = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            s = {1'b0, digits[k]} + ((k == 0) ? {1'b0, lanes} : (CS_BITS+1)'(c[k]));
            w = s - n;
            c[k+1] = k < int'(len) && s >= n;
            if (k < int'(len)) nxt[k] = CS_BITS'(c[k+1] ? w : s);
            if (k + 1 == int'(len)) last = c[k+1];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) digits <= '0;
        else if (init) begin
            digits <= '0;
            digits[0] <= lane;
        end
        else if (inc) digits <= nxt;
    end
endmodule

// File: rtl/keyspace_generator.sv
// keyspace_generator: mixed-radix brute-force candidate generator feeding an MD5 core
module keyspace_generator
    import keyspace_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CS_BITS = 7,
    parameter int ADDR_W = 11,
    parameter int MSG_W = 128,
    parameter int HASH_W = MD5_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         cfg_len,
    input  logic [CS_BITS:0]   cfg_cs_size,
    input  logic [CS_BITS-1:0] cfg_lane,
    input  logic [CS_BITS-1:0] cfg_lanes,
    input  logic [HASH_W-1:0]  target,
    output logic [ADDR_W-1:0]  cs_addr,
    input  logic [7:0]         cs_data,
    output logic [MSG_W-1:0]   msg_out,
    output logic [7:0]         msg_out_width,
    output logic               msg_out_valid,
    input  logic               hash_ready,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic               hash_in_valid,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [MSG_W-1:0]   found_msg,
    output logic [TRIED_W-1:0] tried
);
    localparam int IW = $clog2(MAX_LEN);
    state_t state, state_nxt;
    logic [3:0] len_c, len_r, fk;
    logic [CS_BITS:0] n_r;
    logic [CS_BITS-1:0] lanes_r;
    logic [HASH_W-1:0] target_r;
    logic [MAX_LEN-1:0][7:0] bld;
    logic [MAX_LEN-1:0][CS_BITS-1:0] digits;
    logic outstanding, last, launch, degen, res, match, can_issue;
    assign len_c = (cfg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : cfg_len;
    assign degen = len_c == 4'd0 || {1'b0, cfg_lane} >= cfg_cs_size;
    assign launch = start && !busy;
    assign res = busy && hash_in_valid && outstanding;
    assign match = res && hash_in == target_r;
    // a non-matching digest in the same cycle frees the core for the next issue
    assign can_issue = state == ISSUE && hash_ready && (!outstanding || res) && !match;

    mixed_radix_counter #(.MAX_LEN(MAX_LEN), .CS_BITS(CS_BITS)) u_cnt (
        .clk(clk), .reset(reset), .init(launch), .inc(can_issue), .lane(cfg_lane),
        .lanes(lanes_r), .n(n_r), .len(len_r), .digits(digits), .last(last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FOUND, DONE: if (start) state_nxt = degen ? DONE : FETCH;
            FETCH: if (fk == len_r) state_nxt = ISSUE;
            ISSUE: if (can_issue) state_nxt = last ? DRAIN : FETCH;
            DRAIN: if (res) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (match) state_nxt = FOUND;
    end
    always_comb begin
        busy = state == FETCH || state == ISSUE || state == DRAIN;
        cs_addr = (state == FETCH && fk < len_r) ? ADDR_W'(digits[fk[IW-1:0]]) : '0;
    end

    // msg_out only changes on issue, so it doubles as the in-flight candidate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r <= '0;
            n_r <= '0;
            lanes_r <= '0;
            target_r <= '0;
            fk <= '0;
            bld <= '0;
            outstanding <= 1'b0;
            found <= 1'b0;
            exhausted <= 1'b0;
            found_msg <= '0;
            tried <= '0;
            msg_out <= '0;
            msg_out_width <= '0;
            msg_out_valid <= 1'b0;
        end else begin
            msg_out_valid <= can_issue;
            outstanding <= can_issue || (outstanding && !res);
            if (launch) begin
                len_r <= len_c;
                n_r <= cfg_cs_size;
                lanes_r <= (cfg_lanes == '0) ? CS_BITS'(1) : cfg_lanes;
                target_r <= target;
                msg_out_width <= {1'b0, len_c, 3'b000};
                found <= 1'b0;
                exhausted <= degen;
                tried <= '0;
                bld <= '0;
                fk <= '0;
            end
            if (state == FETCH) begin
                fk <= (fk == len_r) ? 4'd0 : fk + 4'd1;
                if (fk != 4'd0) bld[IW'(fk - 4'd1)] <= cs_data;
            end
            if (can_issue) msg_out <= MSG_W'(bld);
            if (res && !(&tried)) tried <= tried + 1'b1;
            if (match) begin
                found <= 1'b1;
                found_msg <= msg_out;
            end
            else if (res && state == DRAIN) exhausted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_keyspace_generator.sv
// tb_keyspace_generator: table-driven and randomized checks against a keyspace enumeration model
module tb_keyspace_generator;
    localparam logic [127:0] NONE = 128'hdead_beef_0000_0000_0000_0000_0000_0000;
    typedef struct {
        int len, n, lane, lanes, mode;
        logic [127:0] tgt;
        int n_issue;
        bit fnd;
        logic [127:0] fmsg;
    } vec_t;

    logic clk = 0, reset = 1, start = 0;
    logic [3:0] cfg_len = 0;
    logic [7:0] cfg_cs_size = 0;
    logic [6:0] cfg_lane = 0, cfg_lanes = 0;
    logic [127:0] target = 0, hash_in = 0;
    logic hash_ready = 1, hash_in_valid = 0;
    logic [10:0] cs_addr;
    logic [7:0] cs_data;
    logic [127:0] msg_out, found_msg;
    logic [7:0] msg_out_width;
    logic msg_out_valid, busy, found, exhausted;
    logic [47:0] tried;

    logic [7:0] cs_mem [2048];
    logic [127:0] issued[$], exp_q[$], pend_m[$];
    int pend_t[$];
    bit exp_found;
    int n_checks = 0, n_fail = 0, cyc = 0;
    vec_t tbl [8];

    keyspace_generator dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_cs_size(cfg_cs_size),
        .cfg_lane(cfg_lane), .cfg_lanes(cfg_lanes), .target(target), .cs_addr(cs_addr),
        .cs_data(cs_data), .msg_out(msg_out), .msg_out_width(msg_out_width),
        .msg_out_valid(msg_out_valid), .hash_ready(hash_ready), .hash_in(hash_in),
        .hash_in_valid(hash_in_valid), .busy(busy), .found(found), .exhausted(exhausted),
        .found_msg(found_msg), .tried(tried)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cs_data <= cs_mem[cs_addr];

    // hash core: digest equals the message, returned five cycles after issue
    always @(negedge clk) begin
        cyc++;
        hash_in_valid = 0;
        if (pend_t.size() > 0 && pend_t[0] == cyc) begin
            hash_in_valid = 1;
            hash_in = pend_m.pop_front();
            void'(pend_t.pop_front());
        end
        if (msg_out_valid) begin
            issued.push_back(msg_out);
            pend_t.push_back(cyc + 5);
            pend_m.push_back(msg_out);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] cand(input longint v, input int len, input int n);
        logic [127:0] m = '0;
        for (int k = 0; k < len; k++) begin
            m[8*k +: 8] = cs_mem[v % n];
            v = v / n;
        end
        return m;
    endfunction

    // candidates are the base-N numbers lane, lane+lanes, ... below N**len
    task automatic build_model(input int len, input int n, input int lane, input int lanes,
                               input logic [127:0] tgt);
        longint total = 1;
        logic [127:0] m;
        exp_q.delete();
        exp_found = 0;
        if (len > 8) len = 8;
        if (lanes == 0) lanes = 1;
        if (len == 0 || lane >= n) return;
        for (int i = 0; i < len; i++) total *= n;
        for (longint v = lane; v < total; v += lanes) begin
            m = cand(v, len, n);
            exp_q.push_back(m);
            if (m == tgt) begin
                exp_found = 1;
                return;
            end
        end
    endtask

    task automatic run(input vec_t t);
        int len = t.len > 8 ? 8 : t.len;
        bit did = 0;
        int c = 0, vcount = 0, bad = 0;
        logic [127:0] held;
        build_model(t.len, t.n, t.lane, t.lanes, t.tgt);
        issued.delete();
        @(negedge clk);
        cfg_len = 4'(t.len);
        cfg_cs_size = 8'(t.n);
        cfg_lane = 7'(t.lane);
        cfg_lanes = 7'(t.lanes);
        target = t.tgt;
        start = 1;
        @(negedge clk);
        start = 0;
        check("tried_clear", 128'(tried), 128'(0));
        check("width", 128'(msg_out_width), 128'(8 * len));
        if (t.len == 0 || t.lane >= t.n) check("exh_next_cycle", 128'({busy, exhausted}), 128'(2'b01));
        while (busy && c < 5000) begin
            if (t.mode == 1 && !did && issued.size() > 0) begin
                did = 1;
                cfg_len = 4'd1;
                start = 1;
                @(negedge clk);
                start = 0;
                cfg_len = 4'(t.len);
                check("mid_start_width", 128'(msg_out_width), 128'(8 * len));
            end
            if (t.mode == 2 && !did && issued.size() == 3) begin
                did = 1;
                hash_ready = 0;
                repeat (2) @(negedge clk);
                held = msg_out;
                repeat (18) begin
                    @(negedge clk);
                    vcount += int'(msg_out_valid);
                    if (msg_out !== held) vcount += 100;
                end
                hash_ready = 1;
                check("stall_quiet", 128'(vcount), 128'(0));
            end
            @(negedge clk);
            c++;
        end
        check("timeout", 128'(c < 5000), 128'(1));
        repeat (10) @(negedge clk);
        check("n_issued", 128'(issued.size()), 128'(exp_q.size()));
        for (int i = 0; i < issued.size() && i < exp_q.size(); i++) if (issued[i] !== exp_q[i]) bad++;
        check("issue_order", 128'(bad), 128'(0));
        check("found", 128'(found), 128'(exp_found));
        check("exhausted", 128'(exhausted), 128'(!exp_found));
        check("tried", 128'(tried), 128'(exp_q.size()));
        if (exp_found) check("found_msg", found_msg, exp_q[exp_q.size()-1]);
        check("busy_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        vec_t t;
        for (int i = 0; i < 2048; i++) cs_mem[i] = 8'(i + 'h61);
        tbl[0] = '{1, 4, 0, 1, 0, 128'h63, 3, 1, 128'h63};
        tbl[1] = '{2, 3, 0, 1, 0, NONE, 9, 0, 128'h0};
        tbl[2] = '{1, 5, 1, 2, 0, NONE, 2, 0, 128'h0};
        tbl[3] = '{1, 5, 5, 1, 0, NONE, 0, 0, 128'h0};
        tbl[4] = '{0, 4, 0, 1, 0, NONE, 0, 0, 128'h0};
        tbl[5] = '{1, 3, 0, 0, 0, NONE, 3, 0, 128'h0};
        tbl[6] = '{10, 2, 0, 1, 1, 128'h6161616161616262, 4, 1, 128'h6161616161616262};
        tbl[7] = '{2, 4, 0, 1, 2, NONE, 16, 0, 128'h0};

        repeat (3) @(negedge clk);
        check("reset_flags", 128'({busy, found, exhausted, msg_out_valid, tried, msg_out_width, cs_addr}), 128'(0));
        check("reset_msg", msg_out, 128'(0));
        reset = 0;

        foreach (tbl[i]) begin
            run(tbl[i]);
            check("tbl_issues", 128'(issued.size()), 128'(tbl[i].n_issue));
            check("tbl_found", 128'(found), 128'(tbl[i].fnd));
            if (tbl[i].fnd) check("tbl_found_msg", found_msg, tbl[i].fmsg);
        end

        // abort during FETCH while a digest is still in flight
        issued.delete();
        @(negedge clk);
        cfg_len = 4'd3;
        cfg_cs_size = 8'd4;
        cfg_lane = 7'd0;
        cfg_lanes = 7'd1;
        target = NONE;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 100 && issued.size() == 0; c++) @(negedge clk);
        check("first_issue", 128'(issued.size()), 128'(1));
        repeat (2) @(negedge clk);
        check("digest_pending", 128'(pend_t.size() > 0), 128'(1));
        reset = 1;
        #1;
        check("abort_flags", 128'({busy, found, exhausted, msg_out_valid, tried, msg_out_width, cs_addr}), 128'(0));
        check("abort_msg", msg_out, 128'(0));
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (8) @(negedge clk);
        check("late_digest", 128'({tried, busy, found, exhausted}), 128'(0));
        check("late_no_issue", 128'(issued.size()), 128'(1));
        run(tbl[0]);

        for (int r = 0; r < 10; r++) begin
            t.n = int'($urandom_range(2, 6));
            t.len = int'($urandom_range(1, 3));
            t.lane = int'($urandom_range(0, t.n));
            t.lanes = int'($urandom_range(0, t.n - 1));
            t.mode = 0;
            t.tgt = NONE;
            build_model(t.len, t.n, t.lane, t.lanes, t.tgt);
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
                t.tgt = exp_q[$urandom_range(0, exp_q.size() - 1)];
            run(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
